// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: port ids, read-tag layout and default widths.
package mem_arb_pkg;

  localparam int unsigned DEFAULT_AW = 8;
  localparam int unsigned DEFAULT_DW = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One entry per in-flight memory cycle; valid marks a read whose datum must be routed to id.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// LAT-deep shift register of read tags; its output lines up with the memory's q for that read.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [LAT-1:0] stage_q;

  if (LAT == 1) begin : g_single
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= tag_in;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[LAT-2:0], tag_in};
      end
    end
  end

  assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between ports A and B, routing read data back to
// the issuing port and bounding how long B can be held off by a busy A.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEFAULT_AW,
  parameter int unsigned DW         = DEFAULT_DW,
  parameter int unsigned LAT        = 1,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_rden,
  input  logic [DW-1:0] mem_q
);

  // A zero limit behaves as a limit of one: A and B strictly alternate under contention.
  localparam int unsigned THRESH = (MAX_CONSEC == 0) ? 1 : MAX_CONSEC;
  localparam int unsigned CW     = $clog2(THRESH + 1);
  localparam logic [CW-1:0] CntMax = CW'(THRESH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          b_due;
  rd_tag_t       tag_in, tag_out;

  assign b_due = (cnt_q >= CntMax);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      if (a_req && !(b_req && b_due)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_wren  = a_we;
      mem_rden  = ~a_we;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_wren  = b_we;
      mem_rden  = ~b_we;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!b_req || b_gnt) begin
      cnt_d = '0;
    end else if (a_gnt && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tag_in.valid = mem_rden;
  assign tag_in.id    = b_gnt ? PORT_B : PORT_A;

  rd_tag_pipe #(
    .LAT(LAT)
  ) u_rd_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign a_rvalid = tag_out.valid && (tag_out.id == PORT_A);
  assign b_rvalid = tag_out.valid && (tag_out.id == PORT_B);
  assign a_rdata  = a_rvalid ? mem_q : '0;
  assign b_rdata  = b_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter configurations (LAT=1/MAX_CONSEC=4 and LAT=2/MAX_CONSEC=0) share one stimulus
// stream; each is checked every cycle against a cycle-indexed reference model.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load  = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;

  logic       a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2], mem_wren [2], mem_rden [2];
  logic [7:0] a_rdata [2], b_rdata [2], mem_addr [2], mem_wdata [2], mem_q [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(8), .DW(8), .LAT(1), .MAX_CONSEC(4)) dut0 (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wren(mem_wren[0]),
    .mem_rden(mem_rden[0]), .mem_q(mem_q[0])
  );

  mem_port_arbiter #(.AW(8), .DW(8), .LAT(2), .MAX_CONSEC(0)) dut1 (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wren(mem_wren[1]),
    .mem_rden(mem_rden[1]), .mem_q(mem_q[1])
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h01:   return 8'h11;
      8'h02:   return 8'h22;
      8'h03:   return 8'h33;
      8'h05:   return 8'h3C;
      default: return a * 8'd37 + 8'd7;
    endcase
  endfunction

  // Memory instances (not reset); dut1's memory has one extra output register.
  logic [7:0] ram [2][256];
  logic [7:0] q0, q1a, q1b;
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        ram[0][i] <= init_val(8'(i));
        ram[1][i] <= init_val(8'(i));
      end
    end else begin
      if (mem_wren[0]) ram[0][mem_addr[0]] <= mem_wdata[0];
      if (mem_wren[1]) ram[1][mem_addr[1]] <= mem_wdata[1];
    end
    if (mem_rden[0]) q0 <= ram[0][mem_addr[0]];
    if (mem_rden[1]) q1a <= ram[1][mem_addr[1]];
    q1b <= q1a;
  end
  assign mem_q[0] = q0;
  assign mem_q[1] = q1b;

  task automatic note(input logic ok, input string name, input int k, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input int k, input logic act, input logic exp);
    note(act === exp, name, k, {7'd0, act}, {7'd0, exp});
  endtask

  task automatic chk_v(input string name, input int k, input logic [7:0] act,
                       input logic [7:0] exp);
    note(act === exp, name, k, act, exp);
  endtask

  // Reference model: shadow memory, starvation count, and a ring of expected returns keyed by
  // the cycle in which each read datum is due.
  logic [7:0] shadow [2][256];
  int         cnt_m [2];
  logic       ev [2][8];
  logic       ep [2][8];
  logic [7:0] ed [2][8];

  task automatic model_step(input int k);
    int         lat, thr;
    logic [2:0] s, due;
    logic       ga, gb, ew, er, ra, rb;
    logic [7:0] ea, ewd, rd_a, rd_b;
    lat = (k == 0) ? 1 : 2;
    thr = (k == 0) ? 4 : 1;
    s   = 3'(cyc);
    due = 3'(cyc + lat);
    ga = 0; gb = 0; ew = 0; er = 0; ra = 0; rb = 0;
    ea = 0; ewd = 0; rd_a = 0; rd_b = 0;
    if (reset) begin
      cnt_m[k] = 0;
      for (int i = 0; i < 8; i++) ev[k][i] = 1'b0;
    end else begin
      if (a_req && !(b_req && cnt_m[k] >= thr)) ga = 1;
      else if (b_req) gb = 1;
      if (ga) begin ea = a_addr; ewd = a_wdata; ew = a_we; er = !a_we; end
      if (gb) begin ea = b_addr; ewd = b_wdata; ew = b_we; er = !b_we; end
      if (ev[k][s]) begin
        if (ep[k][s]) begin rb = 1; rd_b = ed[k][s]; end
        else begin ra = 1; rd_a = ed[k][s]; end
      end
    end
    chk_b("a_gnt", k, a_gnt[k], ga);
    chk_b("b_gnt", k, b_gnt[k], gb);
    chk_v("mem_addr", k, mem_addr[k], ea);
    chk_v("mem_wdata", k, mem_wdata[k], ewd);
    chk_b("mem_wren", k, mem_wren[k], ew);
    chk_b("mem_rden", k, mem_rden[k], er);
    chk_b("a_rvalid", k, a_rvalid[k], ra);
    chk_v("a_rdata", k, a_rdata[k], rd_a);
    chk_b("b_rvalid", k, b_rvalid[k], rb);
    chk_v("b_rdata", k, b_rdata[k], rd_b);
    if (!reset) begin
      ev[k][s] = 1'b0;
      if (!b_req || gb) cnt_m[k] = 0;
      else if (ga) cnt_m[k] = cnt_m[k] + 1;
      if (ew) shadow[k][ea] = ewd;
      if (er) begin
        ev[k][due] = 1'b1;
        ep[k][due] = gb;
        ed[k][due] = shadow[k][ea];
      end
    end
  endtask

  always @(negedge clock) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        shadow[0][i] = init_val(8'(i));
        shadow[1][i] = init_val(8'(i));
      end
    end
    model_step(0);
    model_step(1);
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    load = 1'b0;
    #1;
    reset = 1'b0;

    // A read of 0x05 (holds 0x3C).
    a_req = 1; a_we = 0; a_addr = 8'h05;
    @(negedge clock);
    chk_b("t1 a_gnt", 0, a_gnt[0], 1'b1);
    chk_b("t1 mem_rden", 0, mem_rden[0], 1'b1);
    chk_v("t1 mem_addr", 0, mem_addr[0], 8'h05);
    chk_b("t1 b_gnt", 0, b_gnt[0], 1'b0);
    next_cycle();
    a_req = 0;
    @(negedge clock);
    chk_b("t1 a_rvalid", 0, a_rvalid[0], 1'b1);
    chk_v("t1 a_rdata", 0, a_rdata[0], 8'h3C);
    chk_b("t1 b_rvalid", 0, b_rvalid[0], 1'b0);
    next_cycle();
    @(negedge clock);
    chk_b("t1 a_rvalid", 1, a_rvalid[1], 1'b1);
    chk_v("t1 a_rdata", 1, a_rdata[1], 8'h3C);

    // B writes 0xA7 to 0x10, then reads it back.
    next_cycle();
    b_req = 1; b_we = 1; b_addr = 8'h10; b_wdata = 8'hA7;
    @(negedge clock);
    chk_b("t2 mem_wren", 0, mem_wren[0], 1'b1);
    chk_b("t2 b_gnt", 0, b_gnt[0], 1'b1);
    next_cycle();
    b_we = 0;
    @(negedge clock);
    chk_b("t2 rd mem_rden", 0, mem_rden[0], 1'b1);
    next_cycle();
    b_req = 0;
    @(negedge clock);
    chk_b("t2 b_rvalid", 0, b_rvalid[0], 1'b1);
    chk_v("t2 b_rdata", 0, b_rdata[0], 8'hA7);
    next_cycle();
    @(negedge clock);
    chk_b("t2 b_rvalid", 1, b_rvalid[1], 1'b1);
    chk_v("t2 b_rdata", 1, b_rdata[1], 8'hA7);

    // Sustained contention: AAAAB for limit 4, ABAB for limit 0.
    next_cycle();
    next_cycle();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    for (int i = 0; i < 12; i++) begin
      a_addr = 8'(i); b_addr = 8'(i + 32);
      @(negedge clock);
      chk_b("t3 a_gnt", 0, a_gnt[0], (i % 5) != 4);
      chk_b("t3 b_gnt", 0, b_gnt[0], (i % 5) == 4);
      chk_b("t3 a_gnt", 1, a_gnt[1], (i % 2) == 0);
      chk_b("t3 b_gnt", 1, b_gnt[1], (i % 2) == 1);
      next_cycle();
    end
    a_req = 0; b_req = 0;
    repeat (3) next_cycle();

    // Back-to-back reads A(0x01), B(0x02), A(0x03).
    for (int j = 0; j < 6; j++) begin
      a_req = (j == 0 || j == 2); b_req = (j == 1);
      a_addr = (j == 0) ? 8'h01 : 8'h03; b_addr = 8'h02;
      @(negedge clock);
      if (j == 2) begin
        chk_b("t6 a_rvalid", 1, a_rvalid[1], 1'b1);
        chk_v("t6 a_rdata", 1, a_rdata[1], 8'h11);
      end
      if (j == 3) begin
        chk_b("t6 b_rvalid", 1, b_rvalid[1], 1'b1);
        chk_v("t6 b_rdata", 1, b_rdata[1], 8'h22);
      end
      if (j == 4) begin
        chk_b("t6 a_rvalid", 1, a_rvalid[1], 1'b1);
        chk_v("t6 a_rdata", 1, a_rdata[1], 8'h33);
      end
      next_cycle();
    end

    // Reset while a read is in flight; A keeps requesting across reset.
    a_req = 1; a_addr = 8'h05;
    @(negedge clock);
    chk_b("t5 a_gnt", 0, a_gnt[0], 1'b1);
    next_cycle();
    reset = 1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        chk_b("t5 rst a_gnt", k, a_gnt[k], 1'b0);
        chk_b("t5 rst a_rvalid", k, a_rvalid[k], 1'b0);
        chk_b("t5 rst mem_rden", k, mem_rden[k], 1'b0);
        chk_v("t5 rst mem_addr", k, mem_addr[k], 8'h00);
      end
      next_cycle();
    end
    reset = 0;
    @(negedge clock);
    chk_b("t5 first a_gnt", 0, a_gnt[0], 1'b1);
    chk_b("t5 first a_gnt", 1, a_gnt[1], 1'b1);
    next_cycle();
    a_req = 0;
    repeat (3) next_cycle();

    // Randomised traffic with occasional resets; checked by the model every cycle.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(99) == 0);
      a_req   = ($urandom_range(3) != 0);
      b_req   = ($urandom_range(2) != 0);
      a_we    = ($urandom_range(2) == 0);
      b_we    = ($urandom_range(2) == 0);
      a_addr  = 8'($urandom_range(15));
      b_addr  = 8'($urandom_range(15));
      a_wdata = 8'($urandom);
      b_wdata = 8'($urandom);
      next_cycle();
    end
    reset = 0; a_req = 0; b_req = 0;
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
